// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequential signed multiply/divide controller.
// A start pulse latches the operands. PREP converts them to magnitudes.
// RUN does WIDTH shift-add or restoring-divide steps on one shared
// add/subtract path. FIX restores the sign and flags overflow. DONE pulses
// data_resultRDY.
//
// Handshake: ctrl_MULT/ctrl_DIV are single-cycle requests with no ready;
// they are accepted at any edge and abort any operation in flight.
// busy is high from the start edge until the cycle before data_resultRDY.
// data_resultRDY is a one-cycle valid qualifying data_result/data_exception.
module multdiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] acc;    // product high half / partial remainder
  logic [WIDTH-1:0] lo;     // multiplier / quotient (operand B / A before PREP)
  logic [WIDTH-1:0] opnd;   // multiplicand / divisor magnitude
  logic             op_div;
  logic             sign;
  logic             div0;
  logic [CNT_W-1:0] cnt;

  logic             start;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_sub;
  logic [WIDTH:0]   add_sum;
  logic             div_ge;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   fix_result;
  logic               fix_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
  endfunction

  // Shared add/subtract path: multiply adds the gated multiplicand, divide
  // subtracts the divisor from the left-shifted remainder (carry = no borrow).
  always_comb begin
    add_sub = op_div;
    add_x   = op_div ? {acc[WIDTH-2:0], lo[WIDTH-1]} : acc;
    add_y   = op_div ? ~opnd : (lo[0] ? opnd : '0);
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_sub};
    div_ge  = add_sum[WIDTH];
  end

  // Sign correction and exception detection for the FIX cycle.
  always_comb begin
    prod_fix = sign ? (~{acc, lo} + (2*WIDTH)'(1)) : {acc, lo};
    quot_fix = sign ? (~lo + WIDTH'(1)) : lo;
    if (div0) begin
      fix_result = '0;
      fix_exc    = 1'b1;
    end else if (op_div) begin
      // A positive quotient with the top bit set only arises from MIN / -1.
      fix_result = quot_fix;
      fix_exc    = ~sign & lo[WIDTH-1];
    end else begin
      fix_result = prod_fix[WIDTH-1:0];
      fix_exc    = (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}});
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a start request overrides every state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_IDLE;
      // Divide by zero skips RUN but still passes through FIX.
      S_PREP: state_nxt = (op_div && lo == '0) ? S_FIX : S_RUN;
      S_RUN:  state_nxt = (cnt == CNT_W'(WIDTH-1)) ? S_FIX : S_RUN;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (start) state_nxt = S_PREP;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc            <= '0;
      lo             <= '0;
      opnd           <= '0;
      op_div         <= 1'b0;
      sign           <= 1'b0;
      div0           <= 1'b0;
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      acc    <= data_operandA;
      lo     <= data_operandB;
      op_div <= ~ctrl_MULT;
      sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0   <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        S_PREP: begin
          acc  <= '0;
          opnd <= op_div ? mag(lo) : mag(acc);
          lo   <= op_div ? mag(acc) : mag(lo);
          div0 <= op_div && (lo == '0);
          cnt  <= '0;
        end
        S_RUN: begin
          if (op_div) begin
            acc <= div_ge ? add_sum[WIDTH-1:0] : add_x;
            lo  <= {lo[WIDTH-2:0], div_ge};
          end else begin
            acc <= add_sum[WIDTH:1];
            lo  <= {add_sum[0], lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          data_result    <= fix_result;
          data_exception <= fix_exc;
        end
        default: ;
      endcase
    end
  end

  assign data_resultRDY = (state == S_DONE);
  assign busy           = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
  assign state_dbg      = state;

endmodule
